// File: rtl/vec_out_pkg.sv
// Shared definitions for the vector output serializer.
// - DEFAULT_DATA_WIDTH / DEFAULT_VECTOR_SIZE / DEFAULT_DEPTH: parameter defaults
// - lane_t : one lane of a vector result
// - vec_t  : a full vector, lane 0 in the least significant bits
// - state_t: serializer FSM states
package vec_out_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_VECTOR_SIZE = 6;
  localparam int DEFAULT_DEPTH       = 4;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] lane_t;
  typedef lane_t [DEFAULT_VECTOR_SIZE-1:0] vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding whole vectors for the serializer.
// Ports:
//   clock, reset      - single clock, synchronous active-high reset
//   push, pop         - already-qualified write / free-head strobes
//   wrData            - entry written on push
//   rdData            - head entry, visible without a read strobe
//   full, empty, count- occupancy status (count is registered)
// The caller must not pop when empty nor push when full unless it also pops.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wrData,
  output logic [WIDTH-1:0]       rdData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [CNT_W-1:0] countReg;

  // Storage is deliberately not reset; the pointers alone define validity.
  // When full, push+pop rewrites the slot being freed, which is safe because
  // the head moves on at the same edge.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wrPtrReg] <= wrData;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (push) wrPtrReg <= wrPtrReg + 1'b1;
      if (pop)  rdPtrReg <= rdPtrReg + 1'b1;
      case ({push, pop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  // Head is read asynchronously: the downstream lane mux must see the new
  // head in the very cycle after a pop to stream without a bubble.
  assign rdData = mem[rdPtrReg];
  assign count  = countReg;
  assign full   = (countReg == CNT_W'(DEPTH));
  assign empty  = (countReg == '0);

endmodule

// File: rtl/vector_out_serializer.sv
// Captures wide CPU writeback vectors into a FIFO and streams them out one
// lane per cycle with a valid/ready handshake.
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   out, outFlag          - vector to capture and its capture strobe
//   laneData, laneValid   - current lane of the head vector (0 when not valid)
//   laneReady             - consumer accepts laneData this cycle
//   laneIndex, lastLane   - lane position, lastLane marks the final lane
//   count, full, empty    - FIFO occupancy including the vector being streamed
//   overflow              - sticky: a strobe arrived while full and not popping
// Assumes VECTOR_SIZE >= 2 and DEPTH a power of two >= 2.
module vector_out_serializer
  import vec_out_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int VECTOR_SIZE = DEFAULT_VECTOR_SIZE,
  parameter int DEPTH       = DEFAULT_DEPTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] out,
  input  logic                            outFlag,
  output logic [DATA_WIDTH-1:0]           laneData,
  output logic                            laneValid,
  input  logic                            laneReady,
  output logic [$clog2(VECTOR_SIZE)-1:0]  laneIndex,
  output logic                            lastLane,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            full,
  output logic                            empty,
  output logic                            overflow
);

  localparam int IDX_W = $clog2(VECTOR_SIZE);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int VEC_W = DATA_WIDTH * VECTOR_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

  state_t           stateReg;
  state_t           stateNext;
  logic [IDX_W-1:0] laneIndexReg;
  logic             overflowReg;
  logic             push;
  logic             pop;
  logic             transfer;
  logic [VEC_W-1:0] headVec;

  // Lane table padded to a power of two so every laneIndex value selects a
  // defined entry; the pad lanes are never reached in operation.
  logic [DATA_WIDTH-1:0] lanes [2**IDX_W];

  sync_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (DEPTH)
  ) uFifo (
    .clock  (clock),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wrData (out),
    .rdData (headVec),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : gLane
    if (gi < VECTOR_SIZE) begin : gReal
      assign lanes[gi] = headVec[gi*DATA_WIDTH +: DATA_WIDTH];
    end else begin : gPad
      assign lanes[gi] = '0;
    end
  end

  // Outputs derive only from registers, keeping outFlag/laneReady off the
  // laneValid/laneData paths.
  assign laneValid = (stateReg == SEND);
  assign laneIndex = laneIndexReg;
  assign lastLane  = laneValid && (laneIndexReg == LAST_IDX);
  assign laneData  = laneValid ? lanes[laneIndexReg] : '0;
  assign overflow  = overflowReg;

  assign transfer = laneValid && laneReady;
  assign pop      = transfer && lastLane;
  // A strobe while full is still taken if the head is freed this same edge.
  assign push     = outFlag && (!full || pop);

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (push) stateNext = SEND;
      SEND: if (pop && !push && count == CNT_W'(1)) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg     <= IDLE;
      laneIndexReg <= '0;
      overflowReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (transfer) begin
        laneIndexReg <= lastLane ? '0 : laneIndexReg + 1'b1;
      end
      if (outFlag && !push) begin
        overflowReg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vector_out_serializer.sv
// Self-checking bench for vector_out_serializer: a directed table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_vector_out_serializer;
  import vec_out_pkg::*;

  localparam int DW    = 16;
  localparam int VS    = 6;
  localparam int DEPTH = 4;
  localparam int VW    = DW * VS;

  logic          clock = 1'b0;
  logic          reset;
  logic [VW-1:0] out;
  logic          outFlag;
  logic [DW-1:0] laneData;
  logic          laneValid;
  logic          laneReady;
  logic [2:0]    laneIndex;
  logic          lastLane;
  logic [2:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  vector_out_serializer #(
    .DATA_WIDTH  (DW),
    .VECTOR_SIZE (VS),
    .DEPTH       (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .out       (out),
    .outFlag   (outFlag),
    .laneData  (laneData),
    .laneValid (laneValid),
    .laneReady (laneReady),
    .laneIndex (laneIndex),
    .lastLane  (lastLane),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of whole vectors plus the lane cursor.
  vec_t          mq[$];
  int            mIdx = 0;
  bit            mOvf = 1'b0;
  logic [DW-1:0] gotLanes[$];

  typedef struct {
    bit            flag;
    bit            ready;
    vec_t          vec;
    bit            eValid;
    logic [DW-1:0] eData;
    int            eIdx;
    bit            eLast;
    int            eCount;
    bit            eFull;
    bit            eEmpty;
    bit            eOvf;
  } row_t;

  row_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkVec(input int base);
    vec_t v;
    for (int k = 0; k < VS; k++) v[k] = lane_t'(base + k);
    return v;
  endfunction

  function automatic row_t mkRow(input bit f, input bit r, input vec_t v, input bit ev,
                                 input int ed, input int ei, input bit el, input int ec,
                                 input bit ef, input bit ee, input bit eo);
    row_t x;
    x.flag = f; x.ready = r; x.vec = v; x.eValid = ev; x.eData = DW'(ed); x.eIdx = ei;
    x.eLast = el; x.eCount = ec; x.eFull = ef; x.eEmpty = ee; x.eOvf = eo;
    return x;
  endfunction

  task automatic checkModel();
    vec_t          head;
    bit            ev;
    logic [DW-1:0] ed;
    ev = (mq.size() > 0);
    ed = '0;
    if (ev) begin
      head = mq[0];
      ed   = head[mIdx];
    end
    chk("laneValid", laneValid, ev);
    chk("laneData", laneData, ed);
    chk("laneIndex", laneIndex, mIdx);
    chk("lastLane", lastLane, ev && mIdx == VS - 1);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("overflow", overflow, mOvf);
  endtask

  function automatic void modelEdge(input bit rst, input bit f, input vec_t v, input bit r);
    bit p;
    bit q;
    if (rst) begin
      mq.delete();
      mIdx = 0;
      mOvf = 1'b0;
      return;
    end
    p = (mq.size() > 0) && r && (mIdx == VS - 1);
    q = f && (mq.size() < DEPTH || p);
    if (f && !q) mOvf = 1'b1;
    if (mq.size() > 0 && r) mIdx = (mIdx == VS - 1) ? 0 : mIdx + 1;
    if (p) begin
      $display("pop vector %h at t=%0t", mq[0], $time);
      void'(mq.pop_front());
    end
    if (q) mq.push_back(v);
  endfunction

  // One clock: drive inputs, check registered outputs, advance the model.
  task automatic step(input bit f, input vec_t v, input bit r);
    outFlag   = f;
    out       = v;
    laneReady = r;
    checkModel();
    if (laneValid && r) gotLanes.push_back(laneData);
    modelEdge(reset, f, v, r);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step(1'b0, '0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    vec_t rv;
    bit   rf;
    bit   rr;

    reset = 1'b1; outFlag = 1'b0; laneReady = 1'b0; out = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single vector, lanes 0x0001..0x0006, consumer always ready.
    tbl[0] = mkRow(1, 1, mkVec(1), 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 6; i++)
      tbl[i] = mkRow(0, 1, '0, 1, i, i - 1, i == 6, 1, 0, 0, 0);
    tbl[7] = mkRow(0, 1, '0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      chk("tbl_laneValid", laneValid, tbl[i].eValid);
      chk("tbl_laneData", laneData, tbl[i].eData);
      chk("tbl_laneIndex", laneIndex, tbl[i].eIdx);
      chk("tbl_lastLane", lastLane, tbl[i].eLast);
      chk("tbl_count", count, tbl[i].eCount);
      chk("tbl_full", full, tbl[i].eFull);
      chk("tbl_empty", empty, tbl[i].eEmpty);
      chk("tbl_overflow", overflow, tbl[i].eOvf);
      step(tbl[i].flag, tbl[i].vec, tbl[i].ready);
    end

    // Backpressure: ready alternates, each lane must appear exactly once in order.
    gotLanes.delete();
    step(1, mkVec(16'h0010), 0);
    for (int j = 0; j < 12; j++) step(0, '0, (j % 2) == 0);
    step(0, '0, 0);
    chk("bp_lane_count", gotLanes.size(), 6);
    for (int k = 0; k < 6 && k < gotLanes.size(); k++) chk("bp_lane", gotLanes[k], 16'h0010 + k);
    chk("bp_empty", empty, 1);

    // Fill and overflow: five strobes while the consumer stalls.
    for (int s = 0; s < 5; s++) begin
      if (s == 4) chk("fill_full_after4", full, 1);
      step(1, mkVec((s + 1) << 8), 0);
    end
    chk("fill_overflow", overflow, 1);
    chk("fill_count", count, 4);
    gotLanes.delete();
    for (int j = 0; j < 25; j++) step(0, '0, 1);
    chk("fill_drain_lanes", gotLanes.size(), 24);
    for (int k = 0; k < 24 && k < gotLanes.size(); k++)
      chk("fill_drain_lane", gotLanes[k], (((k / 6) + 1) << 8) + (k % 6));
    chk("fill_drain_empty", empty, 1);

    // Push and pop on the same edge while full.
    doReset();
    chk("rst_overflow", overflow, 0);
    for (int s = 0; s < 4; s++) step(1, mkVec(16'h0a00 + (s << 4)), 0);
    chk("pp_full", full, 1);
    for (int j = 0; j < 5; j++) step(0, '0, 1);
    chk("pp_lastLane", lastLane, 1);
    step(1, mkVec(16'h0e00), 1);
    chk("pp_count", count, 4);
    chk("pp_overflow", overflow, 0);
    chk("pp_no_bubble_valid", laneValid, 1);
    chk("pp_no_bubble_index", laneIndex, 0);
    chk("pp_next_head", laneData, 16'h0a10);
    for (int j = 0; j < 25; j++) step(0, '0, 1);

    // Reset in the middle of a vector with a second one queued.
    step(1, mkVec(16'h0600), 0);
    step(1, mkVec(16'h0700), 0);
    for (int j = 0; j < 3; j++) step(0, '0, 1);
    chk("mr_index_before", laneIndex, 3);
    reset = 1'b1;
    step(1, mkVec(16'h0800), 1);
    reset = 1'b0;
    chk("mr_laneValid", laneValid, 0);
    chk("mr_count", count, 0);
    chk("mr_laneIndex", laneIndex, 0);
    chk("mr_overflow", overflow, 0);
    chk("mr_laneData", laneData, 0);
    step(1, mkVec(16'h0900), 0);
    chk("mr_restart_valid", laneValid, 1);
    chk("mr_restart_index", laneIndex, 0);
    chk("mr_restart_data", laneData, 16'h0900);
    for (int j = 0; j < 7; j++) step(0, '0, 1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < VS; k++) rv[k] = lane_t'($urandom);
      rf = ($urandom_range(0, 99) < 35);
      rr = ($urandom_range(0, 99) < 60);
      reset = ($urandom_range(0, 299) == 0);
      step(rf, rv, rr);
    end
    reset = 1'b0;
    for (int j = 0; j < 30; j++) step(0, '0, 1);
    chk("final_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
